dmem_access_ctrl: RTL and testbench

Data-memory access controller in the MEM stage. Sequences every data-memory access for the pipeline's MEM-stage load/store. Shares the single data-memory port with one external requester (DMA/debug). Freezes the pipeline registers through `stall_o` while a multi-cycle CPU access is outstanding. Sits between the EX/MEM pipeline register outputs (Mem control bits, ALU address, rt data) and the data memory, and feeds read data toward the MEM/WB register.

---
 rtl/dmem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer with external-port arbitration
// One shared memory port; CPU normally wins, external wins when CPU is idle or after starvation.
module dmem_access_ctrl #(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_o,
  input  logic        ext_req_i,
  input  logic        ext_we_i,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_wdata_i,
  output logic        ext_gnt_o,
  output logic        ext_done_o,
  output logic [31:0] ext_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, EXT_ACC} state_e;

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  starve_cnt_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        ext_gnt_q;
  logic        ext_done_q;
  logic [31:0] ext_rdata_q;
  logic [31:0] cpu_rdata_q;

  logic last_cyc;
  logic ext_win;
  logic cpu_win;

  assign last_cyc = (state_q != IDLE) && (wait_cnt_q == WAIT_LAST);
  assign ext_win  = ext_req_i && ((starve_cnt_q >= STARVE_LIM) || !cpu_req_i);
  assign cpu_win  = !ext_win && cpu_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      starve_cnt_q <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      ext_gnt_q    <= 1'b0;
      ext_done_q   <= 1'b0;
      ext_rdata_q  <= 32'd0;
      cpu_rdata_q  <= 32'd0;
    end else begin
      ext_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ext_win) begin
            state_q     <= EXT_ACC;
            ext_gnt_q   <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= ext_we_i;
            mem_addr_q  <= ext_addr_i;
            mem_wdata_q <= ext_wdata_i;
            wait_cnt_q  <= 4'd0;
          end else if (cpu_win) begin
            state_q     <= CPU_ACC;
            mem_en_q    <= 1'b1;
            mem_we_q    <= cpu_we_i;
            mem_addr_q  <= cpu_addr_i;
            mem_wdata_q <= cpu_wdata_i;
            wait_cnt_q  <= 4'd0;
          end
        end
        CPU_ACC, EXT_ACC: begin
          if (last_cyc) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            wait_cnt_q <= 4'd0;
            ext_gnt_q  <= 1'b0;
            if (state_q == EXT_ACC) begin
              ext_done_q <= 1'b1;
              if (!mem_we_q) ext_rdata_q <= mem_rdata_i;
            end else if (!mem_we_q) begin
              cpu_rdata_q <= mem_rdata_i;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Grant/absence clears first; only a CPU completion seen by a waiting requester counts.
      if (!ext_req_i || (state_q == IDLE && ext_win)) begin
        starve_cnt_q <= 4'd0;
      end else if (state_q == CPU_ACC && last_cyc && starve_cnt_q != 4'd15) begin
        starve_cnt_q <= starve_cnt_q + 4'd1;
      end
    end
  end

  assign stall_o = !rst_i && (((state_q == IDLE)    && cpu_req_i) ||
                              ((state_q == CPU_ACC) && !last_cyc) ||
                              ((state_q == EXT_ACC) && cpu_req_i));

  assign cpu_rdata_o = (state_q == CPU_ACC && last_cyc && !mem_we_q) ? mem_rdata_i : cpu_rdata_q;

  assign ext_gnt_o   = ext_gnt_q;
  assign ext_done_o  = ext_done_q;
  assign ext_rdata_o = ext_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
// Instance 0: WAIT_CYCLES=2, STARVE_LIMIT=2; instance 1: WAIT_CYCLES=0, default STARVE_LIMIT.
module tb_dmem_access_ctrl;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk;
  logic        rst;
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic        stall     [2];
  logic        ext_req   [2];
  logic        ext_we    [2];
  logic [31:0] ext_addr  [2];
  logic [31:0] ext_wdata [2];
  logic        ext_gnt   [2];
  logic        ext_done  [2];
  logic [31:0] ext_rdata [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  int          en_cnt    [2];

  int n_checks = 0;
  int n_fail   = 0;

  acc_t        cq0[$], cq1[$], eq0[$], eq1[$];
  logic [31:0] rq0[$], rq1[$];

  logic        in_acc  [2];
  int          len     [2];
  logic [31:0] cur_addr[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl #(.WAIT_CYCLES(2), .STARVE_LIMIT(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req[0]), .cpu_we_i(cpu_we[0]), .cpu_addr_i(cpu_addr[0]),
    .cpu_wdata_i(cpu_wdata[0]), .cpu_rdata_o(cpu_rdata[0]), .stall_o(stall[0]),
    .ext_req_i(ext_req[0]), .ext_we_i(ext_we[0]), .ext_addr_i(ext_addr[0]),
    .ext_wdata_i(ext_wdata[0]), .ext_gnt_o(ext_gnt[0]), .ext_done_o(ext_done[0]),
    .ext_rdata_o(ext_rdata[0]), .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0])
  );

  dmem_access_ctrl #(.WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req[1]), .cpu_we_i(cpu_we[1]), .cpu_addr_i(cpu_addr[1]),
    .cpu_wdata_i(cpu_wdata[1]), .cpu_rdata_o(cpu_rdata[1]), .stall_o(stall[1]),
    .ext_req_i(ext_req[1]), .ext_we_i(ext_we[1]), .ext_addr_i(ext_addr[1]),
    .ext_wdata_i(ext_wdata[1]), .ext_gnt_o(ext_gnt[1]), .ext_done_o(ext_done[1]),
    .ext_rdata_o(ext_rdata[1]), .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1])
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {16'h0, a[15:0]});
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] out_or(input int d);
    return mem_addr[d] | mem_wdata[d] | cpu_rdata[d] | ext_rdata[d] |
           {27'd0, stall[d], ext_gnt[d], ext_done[d], mem_en[d], mem_we[d]};
  endfunction

  // Memory returns real data only in the last cycle of an access, garbage before.
  assign mem_rdata[0] = (en_cnt[0] == 2) ? model(mem_addr[0]) : 32'hBAD0BAD0;
  assign mem_rdata[1] = (en_cnt[1] == 0) ? model(mem_addr[1]) : 32'hBAD0BAD0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) en_cnt[i] <= mem_en[i] ? en_cnt[i] + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_cpu(input int d, input acc_t e);
    if (d == 0) cq0.push_back(e); else cq1.push_back(e);
  endtask

  task automatic push_ext(input int d, input acc_t e, input logic [31:0] rd);
    if (d == 0) begin eq0.push_back(e); rq0.push_back(rd); end
    else begin eq1.push_back(e); rq1.push_back(rd); end
  endtask

  task automatic pop_acc(input int d, input logic is_ext, output acc_t e, output logic found);
    found = 1'b1;
    e.we = 1'b0; e.addr = 32'd0; e.wdata = 32'd0;
    if (d == 0 && !is_ext && cq0.size() > 0)      e = cq0.pop_front();
    else if (d == 1 && !is_ext && cq1.size() > 0) e = cq1.pop_front();
    else if (d == 0 && is_ext && eq0.size() > 0)  e = eq0.pop_front();
    else if (d == 1 && is_ext && eq1.size() > 0)  e = eq1.pop_front();
    else found = 1'b0;
  endtask

  // Monitor: compares every memory access and external completion against the queues.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_acc[d] = 1'b0;
      end else begin
        if (mem_en[d] && !in_acc[d]) begin
          acc_t e;
          logic found;
          in_acc[d] = 1'b1;
          len[d] = 1;
          pop_acc(d, ext_gnt[d], e, found);
          chk("unexpected_access", {31'd0, found}, 32'd1);
          cur_addr[d] = e.addr;
          chk("mem_we", {31'd0, mem_we[d]}, {31'd0, e.we});
          chk("mem_addr", mem_addr[d], e.addr);
          chk("mem_wdata", mem_wdata[d], e.wdata);
        end else if (mem_en[d]) begin
          len[d]++;
        end else if (in_acc[d]) begin
          in_acc[d] = 1'b0;
          chk("mem_en_cycles", len[d], wait_of(d) + 1);
          chk("mem_we_cleared", {31'd0, mem_we[d]}, 32'd0);
          chk("mem_addr_hold", mem_addr[d], cur_addr[d]);
        end
        if (ext_done[d]) begin
          logic [31:0] rd;
          if (d == 0 && rq0.size() > 0) begin
            rd = rq0.pop_front();
            chk("ext_rdata", ext_rdata[d], rd);
          end else if (d == 1 && rq1.size() > 0) begin
            rd = rq1.pop_front();
            chk("ext_rdata", ext_rdata[d], rd);
          end else begin
            chk("unexpected_ext_done", 32'd1, 32'd0);
          end
        end
      end
    end
  end

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic cpu_access(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input int exp_stall, input logic keep);
    acc_t e;
    int   n;
    logic fell;
    cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    e.we = we; e.addr = addr; e.wdata = wdata;
    push_cpu(d, e);
    n = 0;
    fell = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall[d]) begin
        fell = 1'b1;
        break;
      end
      n++;
    end
    chk("cpu_timeout", {31'd0, fell}, 32'd1);
    chk("cpu_stall_cycles", n, exp_stall);
    chk("cpu_rdata_final", cpu_rdata[d], exp_rd);
    @(posedge clk); #1;
    if (!keep) begin
      cpu_req[d] = 1'b0;
      @(negedge clk);
      chk("cpu_rdata_hold", cpu_rdata[d], exp_rd);
      @(posedge clk); #1;
    end
  endtask

  task automatic ext_access(input int d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd,
                            input int exp_gnt, input logic chk_stall);
    acc_t e;
    int   ng;
    int   ns;
    logic got;
    ext_req[d] = 1'b1; ext_we[d] = we; ext_addr[d] = addr; ext_wdata[d] = wdata;
    e.we = we; e.addr = addr; e.wdata = wdata;
    push_ext(d, e, exp_rd);
    ng = 0; ns = 0; got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ext_gnt[d]) ng++;
      if (stall[d]) ns++;
      if (ext_done[d]) begin
        got = 1'b1;
        ext_req[d] = 1'b0;
        break;
      end
    end
    chk("ext_timeout", {31'd0, got}, 32'd1);
    chk("ext_gnt_cycles", ng, exp_gnt);
    if (chk_stall) chk("ext_no_stall", ns, 0);
    @(negedge clk);
    chk("ext_done_width", {31'd0, ext_done[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = 32'd0; cpu_wdata[d] = 32'd0;
      ext_req[d] = 1'b0; ext_we[d] = 1'b0; ext_addr[d] = 32'd0; ext_wdata[d] = 32'd0;
    end
    #1;
    chk("reset_outputs_a", out_or(0), 32'd0);
    chk("reset_outputs_b", out_or(1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_a", out_or(0), 32'd0);

    cpu_access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    cpu_access(0, 1'b1, 32'h20, 32'h1234, 32'hDEADBEEF, 3, 1'b0);
    ext_access(0, 1'b0, 32'h40, 32'h0, model(32'h40), 3, 1'b1);

    fork
      begin
        cpu_access(0, 1'b0, 32'h300, 32'h0, model(32'h300), 3, 1'b1);
        cpu_access(0, 1'b0, 32'h304, 32'h0, model(32'h304), 3, 1'b1);
        cpu_access(0, 1'b0, 32'h308, 32'h0, model(32'h308), 7, 1'b0);
      end
      ext_access(0, 1'b0, 32'h400, 32'h0, model(32'h400), 3, 1'b0);
    join
    chk("starve_cnt_cleared", {28'd0, dut_a.starve_cnt_q}, 32'd0);

    cpu_access(1, 1'b0, 32'h100, 32'h0, model(32'h100), 1, 1'b0);
    ext_access(1, 1'b0, 32'h200, 32'h0, model(32'h200), 1, 1'b1);
    cpu_access(1, 1'b1, 32'h104, 32'hABCD, model(32'h100), 1, 1'b0);
    cpu_access(1, 1'b0, 32'h108, 32'h0, model(32'h108), 1, 1'b0);
    ext_access(1, 1'b1, 32'h204, 32'h55, model(32'h200), 1, 1'b1);

    begin
      acc_t e;
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h80; cpu_wdata[0] = 32'h0;
      e.we = 1'b0; e.addr = 32'h80; e.wdata = 32'h0;
      push_cpu(0, e);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("reset_abort_outputs", out_or(0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_access(0, 1'b0, 32'h80, 32'h0, model(32'h80), 3, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("pending_cpu_a", cq0.size(), 0);
    chk("pending_cpu_b", cq1.size(), 0);
    chk("pending_ext_a", eq0.size() + rq0.size(), 0);
    chk("pending_ext_b", eq1.size() + rq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
